// File: rtl/fix2float_pkg.sv
// Shared helpers for the fix2float arbiter: port-width functions, float zero
// constants and the round-robin next-pointer function.
package fix2float_pkg;

   localparam logic [31:0] FLOAT_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FLOAT_NEG_ZERO = 32'h8000_0000;

   function automatic int calcFw(input int intBits, input int fracBits);
      return intBits + fracBits + 1;
   endfunction

   function automatic int calcIw(input int numReq);
      return (numReq <= 2) ? 1 : $clog2(numReq);
   endfunction

   function automatic int rrNextPtr(input int grant, input int numReq);
      return (grant + 1 >= numReq) ? 0 : grant + 1;
   endfunction

endpackage

// File: rtl/fix2float.sv
// Combinational signed fixed-point to IEEE754 single converter.
// Mantissa is truncated; a zero magnitude yields a signed zero.
module fix2float
   import fix2float_pkg::*;
#(
   parameter int INT_BITS  = 4,
   parameter int FRAC_BITS = 30,
   localparam int FW = calcFw(INT_BITS, FRAC_BITS),
   localparam int MW = FW - 1
)(
   input  logic [FW-1:0] fixed_i,
   output logic [31:0]   float_o
);

   logic          sign;
   logic [MW-1:0] mag;
   logic [MW-1:0] norm;
   logic [MW+22:0] wide;
   logic [22:0]   mant;
   logic [7:0]    expo;
   int            lead;

   // Leading-one position sets the exponent; shifting it to the top of a
   // wide window leaves the 23 fraction bits directly below it.
   always_comb begin
      sign = fixed_i[FW-1];
      mag  = sign ? ((~fixed_i[MW-1:0]) + MW'(1)) : fixed_i[MW-1:0];
      lead = 0;
      for (int b = 0; b < MW; b++) begin
         if (mag[b]) begin
            lead = b;
         end
      end
      norm = mag << (MW - 1 - lead);
      wide = {norm, 23'b0} >> (MW - 1);
      mant = 23'(wide);
      expo = 8'(lead - FRAC_BITS + 127);
      if (mag == '0) begin
         float_o = sign ? FLOAT_NEG_ZERO : FLOAT_POS_ZERO;
      end else begin
         float_o = {sign, expo, mant};
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or after the pointer, with wrap.
// The pointer advances past the grantee only when the grant is accepted.
module rr_arbiter
   import fix2float_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IW = calcIw(NUM_REQ)
)(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               enable_i,
   input  logic [NUM_REQ-1:0] valid_i,
   output logic [NUM_REQ-1:0] ready_o,
   output logic [IW-1:0]      grant_o,
   output logic               accept_o
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW-1:0] grantIdx;
   logic          found;

   always_comb begin
      found    = 1'b0;
      grantIdx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
            found    = 1'b1;
            grantIdx = IW'((int'(ptr_q) + k) % NUM_REQ);
         end
      end
   end

   assign accept_o = enable_i && found;
   assign grant_o  = grantIdx;

   always_comb begin
      ready_o = '0;
      ptr_d   = ptr_q;
      if (accept_o) begin
         ready_o[grantIdx] = 1'b1;
         ptr_d             = IW'(rrNextPtr(int'(grantIdx), NUM_REQ));
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fix2float_arbiter.sv
// Shares one fix2float converter among NUM_REQ requesters with round-robin
// arbitration. Define FIX2FLOAT_ARB_PIPE_EN to add an input register stage.
module fix2float_arbiter
   import fix2float_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int INT_BITS  = 4,
   parameter int FRAC_BITS = 30,
   localparam int FW = calcFw(INT_BITS, FRAC_BITS),
   localparam int IW = calcIw(NUM_REQ)
)(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [NUM_REQ*FW-1:0] req_fixed_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_float_o,
   output logic [IW-1:0]         rsp_id_o,
   output logic                  busy_o
);

   logic          rstDone_q;
   logic          outAccept;
   logic          arbEnable;
   logic          arbAccept;
   logic [IW-1:0] grantIdx;
   logic [FW-1:0] grantFixed;
   logic [FW-1:0] convFixed;
   logic [31:0]   convFloat;
   logic [IW-1:0] convId;
   logic          convValid;

   logic          rspValid_q, rspValid_d;
   logic [31:0]   rspFloat_q, rspFloat_d;
   logic [IW-1:0] rspId_q, rspId_d;

   // Requesters see no ready until one clock edge has passed after reset release.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rstDone_q <= 1'b0;
      end else begin
         rstDone_q <= 1'b1;
      end
   end

   assign outAccept  = !rspValid_q || rsp_ready_i;
   assign grantFixed = req_fixed_i[int'(grantIdx)*FW +: FW];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) uArb (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .enable_i (arbEnable),
      .valid_i  (req_valid_i),
      .ready_o  (req_ready_o),
      .grant_o  (grantIdx),
      .accept_o (arbAccept)
   );

`ifdef FIX2FLOAT_ARB_PIPE_EN
   logic          s1Valid_q, s1Valid_d;
   logic [FW-1:0] s1Fixed_q, s1Fixed_d;
   logic [IW-1:0] s1Id_q, s1Id_d;

   assign arbEnable = rstDone_q && (!s1Valid_q || outAccept);

   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Fixed_d = s1Fixed_q;
      s1Id_d    = s1Id_q;
      if (!s1Valid_q || outAccept) begin
         s1Valid_d = arbAccept;
         if (arbAccept) begin
            s1Fixed_d = grantFixed;
            s1Id_d    = grantIdx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1Valid_q <= 1'b0;
         s1Fixed_q <= '0;
         s1Id_q    <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Fixed_q <= s1Fixed_d;
         s1Id_q    <= s1Id_d;
      end
   end

   assign convFixed = s1Fixed_q;
   assign convId    = s1Id_q;
   assign convValid = s1Valid_q;
   assign busy_o    = s1Valid_q || rspValid_q;
`else
   assign arbEnable = rstDone_q && outAccept;
   assign convFixed = grantFixed;
   assign convId    = grantIdx;
   assign convValid = arbAccept;
   assign busy_o    = rspValid_q;
`endif

   fix2float #(
      .INT_BITS  (INT_BITS),
      .FRAC_BITS (FRAC_BITS)
   ) uConv (
      .fixed_i (convFixed),
      .float_o (convFloat)
   );

   // Output register holds its payload while stalled and reloads on drain.
   always_comb begin
      rspValid_d = rspValid_q;
      rspFloat_d = rspFloat_q;
      rspId_d    = rspId_q;
      if (outAccept) begin
         rspValid_d = convValid;
         if (convValid) begin
            rspFloat_d = convFloat;
            rspId_d    = convId;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rspValid_q <= 1'b0;
         rspFloat_q <= '0;
         rspId_q    <= '0;
      end else begin
         rspValid_q <= rspValid_d;
         rspFloat_q <= rspFloat_d;
         rspId_q    <= rspId_d;
      end
   end

   assign rsp_valid_o = rspValid_q;
   assign rsp_float_o = rspFloat_q;
   assign rsp_id_o    = rspId_q;

endmodule

// File: tb/tb_fix2float_arbiter.sv
// Self-checking bench for fix2float_arbiter: vector table, multi-cycle corner
// sequences and a random stream, all checked through a response scoreboard.
module tb_fix2float_arbiter;

   localparam int NR = 4;
   localparam int FWB = 35;
`ifdef FIX2FLOAT_ARB_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic              clk_i;
   logic              rst_n_i;
   logic [NR-1:0]     req_valid_i;
   logic [NR-1:0]     req_ready_o;
   logic [NR*FWB-1:0] req_fixed_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [31:0]       rsp_float_o;
   logic [1:0]        rsp_id_o;
   logic              busy_o;

   typedef struct {
      logic [34:0] fixed;
      logic [31:0] expFloat;
      int          req;
   } vec_t;

   typedef struct {
      logic [31:0] flt;
      logic [1:0]  id;
   } sb_t;

   sb_t         sbQ[$];
   logic [31:0] expFloatOf[NR];
   logic [NR-1:0] lastAccept;
   int          total;
   int          bad;
   vec_t        vecs[12];

   fix2float_arbiter #(
      .NUM_REQ   (NR),
      .INT_BITS  (4),
      .FRAC_BITS (30)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_fixed_i (req_fixed_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_float_o (rsp_float_o),
      .rsp_id_o    (rsp_id_o),
      .busy_o      (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference conversion by repeated left-normalisation.
   function automatic logic [31:0] refConv(input logic [34:0] fx);
      logic        s;
      logic [33:0] m;
      int          e;
      s = fx[34];
      m = s ? (34'd0 - fx[33:0]) : fx[33:0];
      if (m == 34'd0) return {s, 31'b0};
      e = 33;
      while (!m[33]) begin
         m = m << 1;
         e--;
      end
      return {s, 8'(e - 30 + 127), m[32:10]};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic v, input logic [34:0] fx, input logic [31:0] expF);
      req_valid_i[idx]           = v;
      req_fixed_i[idx*FWB +: FWB] = fx;
      expFloatOf[idx]            = expF;
   endtask

   task automatic newReq(input int i);
      logic [34:0] fx;
      case ($urandom_range(0, 5))
         0:       fx = '0;
         1:       fx = 35'h4_0000_0000;
         default: fx = {3'($urandom()), $urandom()};
      endcase
      applyStimulus(i, 1'b1, fx, refConv(fx));
   endtask

   // One cycle: drive after the edge, return at the following negedge.
   task automatic streamCycle(input logic [NR-1:0] mask, input logic rdy);
      @(posedge clk_i);
      #1;
      rsp_ready_i = rdy;
      for (int i = 0; i < NR; i++) begin
         if (!req_valid_i[i] || lastAccept[i]) begin
            if (mask[i]) newReq(i);
            else req_valid_i[i] = 1'b0;
         end
      end
      @(negedge clk_i);
   endtask

   task automatic drainAll(input string tag);
      int n;
      n = 0;
      while ((req_valid_i != '0 || busy_o || sbQ.size() != 0) && n < 60) begin
         streamCycle('0, 1'b1);
         n++;
      end
      checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
      checkOutput({tag, "_left"}, 64'(sbQ.size()), 64'd0);
   endtask

   task automatic doReset();
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b0;
      sbQ.delete();
      #1;
      checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      checkOutput("rst_rsp_float", 64'(rsp_float_o), 64'd0);
      checkOutput("rst_rsp_id", 64'(rsp_id_o), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   // Scoreboard: pop on response transfer, push on request acceptance.
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         lastAccept = '0;
      end else begin
         if (rsp_valid_o && rsp_ready_i) begin
            if (sbQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL rsp_extra: got id %0d float 0x%0h with nothing expected", rsp_id_o, rsp_float_o);
            end else begin
               sb_t e;
               e = sbQ.pop_front();
               checkOutput("rsp_float", 64'(rsp_float_o), 64'(e.flt));
               checkOutput("rsp_id", 64'(rsp_id_o), 64'(e.id));
            end
         end
         lastAccept = req_valid_i & req_ready_o;
         for (int i = 0; i < NR; i++) begin
            if (lastAccept[i]) sbQ.push_back('{flt: expFloatOf[i], id: 2'(i)});
         end
      end
   end

   initial begin
      int          lat;
      int          waited;
      logic [31:0] holdFloat;
      logic [1:0]  holdId;

      total = 0;
      bad = 0;
      vecs[0]  = '{35'h0_4000_0000, 32'h3F80_0000, 0};
      vecs[1]  = '{35'h7_C000_0000, 32'hBF80_0000, 1};
      vecs[2]  = '{35'h0_A000_0000, 32'h4020_0000, 2};
      vecs[3]  = '{35'h4_0000_0000, 32'h8000_0000, 3};
      vecs[4]  = '{35'h0_0000_0000, 32'h0000_0000, 0};
      vecs[5]  = '{35'h0_0000_0001, 32'h3080_0000, 1};
      vecs[6]  = '{35'h3_FFFF_FFFF, 32'h417F_FFFF, 2};
      vecs[7]  = '{35'h4_0000_0001, 32'hC17F_FFFF, 3};
      vecs[8]  = '{35'h7_FFFF_FFFF, 32'hB080_0000, 0};
      vecs[9]  = '{35'h0_6000_0000, 32'h3FC0_0000, 1};
      vecs[10] = '{35'h0_2000_0000, 32'h3F00_0000, 2};
      vecs[11] = '{35'h0_4000_007F, 32'h3F80_0000, 3};

      rst_n_i = 1'b1;
      req_valid_i = '1;
      req_fixed_i = '0;
      rsp_ready_i = 1'b1;
      lastAccept = '0;
      for (int i = 0; i < NR; i++) expFloatOf[i] = 32'h0;
      doReset();
      req_valid_i = '0;

      $display("[TB] single request latency");
      @(posedge clk_i);
      #1;
      applyStimulus(0, 1'b1, vecs[0].fixed, vecs[0].expFloat);
      @(negedge clk_i);
      checkOutput("t1_ready", 64'(req_ready_o), 64'h1);
      @(posedge clk_i);
      #1;
      req_valid_i[0] = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 10) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      checkOutput("t1_latency", 64'(lat), 64'(LAT));

      $display("[TB] conversion vector table");
      for (int t = 0; t < 12; t++) begin
         @(posedge clk_i);
         #1;
         applyStimulus(vecs[t].req, 1'b1, vecs[t].fixed, vecs[t].expFloat);
         waited = 0;
         @(negedge clk_i);
         while (!req_ready_o[vecs[t].req] && waited < 20) begin
            @(negedge clk_i);
            waited++;
         end
         if (waited >= 20) begin
            total++;
            bad++;
            $display("[TB] FAIL vec_accept: vector %0d never accepted, ready=0x%0h", t, req_ready_o);
         end
         @(posedge clk_i);
         #1;
         req_valid_i[vecs[t].req] = 1'b0;
      end
      drainAll("vec_drain");

      $display("[TB] all requesters streaming");
      doReset();
      for (int k = 0; k < 8; k++) begin
         streamCycle('1, 1'b1);
         checkOutput("t3_grant", 64'(req_ready_o), 64'(4'b0001 << (k % 4)));
         if (k >= LAT) checkOutput("t3_nogap", 64'(rsp_valid_o), 64'd1);
      end

      $display("[TB] backpressure mid-stream");
      repeat (2) streamCycle('1, 1'b1);
      holdFloat = '0;
      holdId = '0;
      for (int s = 0; s < 5; s++) begin
         streamCycle('1, 1'b0);
         if (s == 0) begin
            holdFloat = rsp_float_o;
            holdId = rsp_id_o;
         end else begin
            checkOutput("t4_hold_valid", 64'(rsp_valid_o), 64'd1);
            checkOutput("t4_hold_float", 64'(rsp_float_o), 64'(holdFloat));
            checkOutput("t4_hold_id", 64'(rsp_id_o), 64'(holdId));
            checkOutput("t4_stall_ready", 64'(req_ready_o), 64'd0);
         end
      end
      checkOutput("t4_buffered", 64'(sbQ.size()), 64'(LAT));
      checkOutput("t4_busy", 64'(busy_o), 64'd1);
      repeat (6) streamCycle('1, 1'b1);
      drainAll("t4_drain");

      $display("[TB] reset with full pipeline");
      repeat (3) streamCycle('1, 1'b0);
      checkOutput("t5_full_busy", 64'(busy_o), 64'd1);
      doReset();
      @(negedge clk_i);
      checkOutput("t5_ready_first", 64'(req_ready_o), 64'd0);
      streamCycle('1, 1'b1);
      checkOutput("t5_ptr_zero", 64'(req_ready_o), 64'h1);
      drainAll("t5_drain");

      $display("[TB] pointer wrap");
      doReset();
      streamCycle('0, 1'b1);
      streamCycle(4'b0100, 1'b1);
      checkOutput("t6_grant2_a", 64'(req_ready_o), 64'b0100);
      streamCycle(4'b0100, 1'b1);
      checkOutput("t6_grant2_wrap", 64'(req_ready_o), 64'b0100);
      streamCycle('1, 1'b1);
      checkOutput("t6_ptr3", 64'(req_ready_o), 64'b1000);
      drainAll("t6_drain");

      $display("[TB] random traffic");
      for (int r = 0; r < 200; r++) begin
         streamCycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end
      drainAll("rand_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
